ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
// Parametrised PS/2 keyboard receiver that succeeds the single-key front end.
// Frames 11-bit PS/2 packets and checks start, stop and odd parity.
// Decodes E0 (extended) and F0 (break) prefixes into make/break key events.
// Queues events in a FIFO with valid/ready handshake; drives a retriggerable write-enable pulse to the text/command logic.
// PARAMETERS
// CLK_DIV        250         clk cycles per sample tick (ps2 lines sampled once per tick)
// TIMEOUT_TICKS  4000        ticks without a ps2_clk falling edge before a partial frame aborts
// FIFO_DEPTH     8           event FIFO entries, power of 2, >=2
// HOLD_CYCLES    10_000_000  clk cycles hold_en stays high after the last make event
// PORTS
// clk         in   1   system clock
// rst         in   1   synchronous reset, active-high
// ps2_clk     in   1   PS/2 clock line (asynchronous)
// ps2_data    in   1   PS/2 data line (asynchronous)
// key_valid   out  1   FIFO head holds an event
// key_ready   in   1   consumer accepts head event
// key_code    out  8   scan code at FIFO head (0 when empty)
// key_ext     out  1   head event was E0-prefixed
// key_break   out  1   head event was F0-prefixed (release)
// frame_err   out  1   1-cycle pulse: bad start/stop/parity or timeout abort
// overflow    out  1   sticky: an event was dropped on a full FIFO; cleared by rst only
// hold_en     out  1   high for HOLD_CYCLES after each accepted make event
// fifo_count  out  $clog2(FIFO_DEPTH+1)  entries in FIFO
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; FIFO empty; prefix flags, tick/timeout/hold counters cleared. Reset mid-frame discards the partial frame.
// - ps2_clk and ps2_data each pass a 2-FF synchroniser. A tick pulses 1 cycle every CLK_DIV clk cycles. The FSM runs only on tick cycles.
// - A falling edge is synced ps2_clk equal to 1 at the previous tick and 0 at this tick. On each falling edge, shift in synced ps2_data LSB-first.
// - FSM states:
//   - IDLE: on a falling edge, shift the bit, set bitcnt=1 and go to SHIFT.
//   - SHIFT: each falling edge shifts and increments bitcnt. When bitcnt reaches 11, go to CHECK.
//   - SHIFT timeout: the timeout counter clears on every edge. If it reaches TIMEOUT_TICKS, pulse frame_err and return to IDLE.
//   - CHECK (1 clk cycle, not tick-gated): the frame is valid iff start==0, stop==1 and XOR(data[7:0], parity)==1. On a valid frame, pass the byte to the decoder. Otherwise pulse frame_err. Then go to IDLE.
// - Decoder, one byte per CHECK:
//   - E0 sets ext.
//   - F0 sets brk.
//   - FA/AA (ACK/BAT) are dropped and leave the flags unchanged.
//   - Any other byte writes the event {ext, brk, byte} to the FIFO the next cycle and clears both flags.
//   - A frame error clears both flags.
// - Latency: with the FIFO empty, key_valid rises exactly 2 clk cycles after the tick that samples the 11th falling edge.
// - FIFO (show-ahead):
//   - key_valid = !empty; head fields are valid while key_valid=1.
//   - A pop occurs when key_valid && key_ready. A push occurs on a decoder write.
//   - Full, push without pop: the event is dropped and overflow is set.
//   - Full, push with pop in the same cycle: both occur and count is unchanged.
//   - Empty: a push and a ready in the same cycle produce no pop; key_valid rises next cycle.
//   - Pointers wrap modulo FIFO_DEPTH.
// - hold_en: a pushed event with brk==0 sets hold_en=1 and loads the hold counter with HOLD_CYCLES. The counter decrements each cycle and hold_en falls when it reaches 0. A new make event reloads the counter. Break events do not affect hold_en.
// - Counter widths derive from the parameters via $clog2. No counter wraps silently.
// TESTING
// - PS/2 frame 0x5A, parity 1 -> one event {ext=0,brk=0,code=5A}; key_valid 2 clk after the last tick; hold_en high for HOLD_CYCLES.
// - Frames E0,F0,75 -> a single event {ext=1,brk=1,code=75}; hold_en unchanged; no events for the prefixes.
// - Frame 0x29 with wrong parity -> 1-cycle frame_err; no event; the next good 0x66 yields {0,0,66}.
// - Send 5 bits then stop ps2_clk -> frame_err after TIMEOUT_TICKS ticks; a following 0x72 frame decodes correctly.
// - key_ready=0 and FIFO_DEPTH+1 make codes (0x01..0x09 with depth 8) -> overflow=1, fifo_count=8; pops return 0x01..0x08 in order.
// - Assert rst at bit 6 of a frame -> all outputs 0; the next full frame 0x5A decodes normally.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: framing and parity check, E0/F0 prefix decoding,
// a show-ahead event FIFO with valid/ready, and a retriggerable hold enable.
module ps2_key_decoder #(
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_DEPTH    = 8,
    parameter int HOLD_CYCLES   = 10_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    output logic                              key_valid,
    input  logic                              key_ready,
    output logic [7:0]                        key_code,
    output logic                              key_ext,
    output logic                              key_break,
    output logic                              frame_err,
    output logic                              overflow,
    output logic                              hold_en,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Line synchronisers and sample tick
    logic clk_meta, clk_s, data_meta, data_s, clk_prev;
    logic [DIV_W-1:0] div_cnt;
    logic tick, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 1'b0;
            clk_s     <= 1'b0;
            data_meta <= 1'b0;
            data_s    <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk;
            clk_s     <= clk_meta;
            data_meta <= ps2_data;
            data_s    <= data_meta;
        end
    end

    assign tick = (div_cnt == DIV_LAST);
    assign fall = tick & clk_prev & ~clk_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            clk_prev <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) clk_prev <= clk_s;
        end
    end

    // Framing FSM
    state_t           state, state_nx;
    logic [3:0]       bitcnt, bitcnt_nx;
    logic [TMO_W-1:0] tmo_cnt, tmo_nx;
    logic [10:0]      shreg, shreg_nx;
    logic             abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bitcnt  <= 4'd0;
            tmo_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            bitcnt  <= bitcnt_nx;
            tmo_cnt <= tmo_nx;
            shreg   <= shreg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        bitcnt_nx = bitcnt;
        tmo_nx    = tmo_cnt;
        shreg_nx  = shreg;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                tmo_nx = '0;
                if (fall) begin
                    shreg_nx  = {data_s, shreg[10:1]};
                    bitcnt_nx = 4'd1;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    shreg_nx  = {data_s, shreg[10:1]};
                    bitcnt_nx = bitcnt + 4'd1;
                    tmo_nx    = '0;
                    if (bitcnt == 4'd10) state_nx = CHECK;
                end else if (tick) begin
                    // Abort on the TIMEOUT_TICKS-th consecutive tick with no edge
                    if (tmo_cnt == TMO_LAST) begin
                        abort    = 1'b1;
                        tmo_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        tmo_nx = tmo_cnt + TMO_W'(1);
                    end
                end
            end
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // shreg after 11 bits: [0] start, [8:1] data LSB-first, [9] parity, [10] stop
    logic       frame_ok;
    logic [7:0] frame_byte;
    assign frame_byte = shreg[8:1];
    assign frame_ok   = ~shreg[0] & shreg[10] & (^shreg[9:1]);

    // Prefix decoder; the event word is {ext, brk, code}
    logic       ext_flag, brk_flag, dec_wr;
    logic [9:0] dec_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            dec_wr    <= 1'b0;
            dec_word  <= '0;
            frame_err <= 1'b0;
        end else begin
            dec_wr    <= 1'b0;
            frame_err <= abort;
            if (abort) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (state == CHECK) begin
                if (!frame_ok) begin
                    frame_err <= 1'b1;
                    ext_flag  <= 1'b0;
                    brk_flag  <= 1'b0;
                end else begin
                    case (frame_byte)
                        8'hE0: ext_flag <= 1'b1;
                        8'hF0: brk_flag <= 1'b1;
                        8'hFA, 8'hAA: begin
                        end
                        default: begin
                            dec_wr   <= 1'b1;
                            dec_word <= {ext_flag, brk_flag, frame_byte};
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Show-ahead event FIFO
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, do_pop, do_push;

    assign key_valid  = (count != '0);
    assign full       = (count == CNT_FULL);
    assign do_pop     = key_valid & key_ready;
    assign do_push    = dec_wr & (~full | do_pop);
    assign fifo_count = count;
    assign key_code   = key_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign key_break  = key_valid & mem[rd_ptr][8];
    assign key_ext    = key_valid & mem[rd_ptr][9];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= dec_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (dec_wr && full && !do_pop) overflow <= 1'b1;
        end
    end

    // Hold enable: reloaded by every accepted make event
    logic [HOLD_W-1:0] hold_cnt;
    assign hold_en = (hold_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (do_push && !dec_word[8]) begin
            hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames on the sample-tick
// grid and checks every cycle against an event-level model plus literal pins.
module tb_ps2_key_decoder;

    localparam int CLK_DIV       = 4;
    localparam int TIMEOUT_TICKS = 12;
    localparam int FIFO_DEPTH    = 8;
    localparam int HOLD_CYCLES   = 60;
    localparam int CNT_W         = $clog2(FIFO_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ps2_clk = 1'b1;
    logic             ps2_data = 1'b1;
    logic             key_ready = 1'b0;
    logic             key_valid, key_ext, key_break, frame_err, overflow, hold_en;
    logic [7:0]       key_code;
    logic [CNT_W-1:0] fifo_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tb_div = 0;

    ps2_key_decoder #(
        .CLK_DIV(CLK_DIV), .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .FIFO_DEPTH(FIFO_DEPTH), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_ext(key_ext), .key_break(key_break), .frame_err(frame_err),
        .overflow(overflow), .hold_en(hold_en), .fifo_count(fifo_count)
    );

    // ---------------- clock / reset / tick grid ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) tb_div <= 0;
        else     tb_div <= (tb_div == CLK_DIV - 1) ? 0 : tb_div + 1;
    end

    // ---------------- model state ----------------
    logic [9:0] exp_q[$];
    int         push_cyc_q[$];
    logic [9:0] push_ev_q[$];
    int         err_q[$];
    logic       m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0, exp_err = 1'b0;
    int         m_hold = 0;
    bit         live = 1'b0;
    logic       rst_prev = 1'b0, ready_prev = 1'b0;
    logic       kv_prev = 1'b0, he_prev = 1'b0;
    int         valid_rise_cyc = -1, hold_rise_cyc = -1, hold_fall_cyc = -1;
    int         err_cnt = 0, err_last_cyc = -1;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Decoder rules applied when the bench drives the 11th falling edge at cycle e
    task automatic model_frame(input logic [7:0] b, input logic ok, input int e);
        if (!ok) begin
            err_q.push_back(e + CLK_DIV + 1);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b != 8'hFA && b != 8'hAA) begin
            push_cyc_q.push_back(e + CLK_DIV + 2);
            push_ev_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        logic       pop_now, push_now, accept;
        logic [9:0] ev;
        exp_err = 1'b0;
        if (rst_prev) begin
            exp_q.delete(); push_cyc_q.delete(); push_ev_q.delete(); err_q.delete();
            m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; m_hold = 0;
            live = 1'b1;
        end else if (live) begin
            pop_now  = (exp_q.size() > 0) && ready_prev;
            push_now = (push_cyc_q.size() > 0) && (push_cyc_q[0] == cyc);
            accept   = 1'b0;
            ev       = '0;
            if (push_now) begin
                ev = push_ev_q.pop_front();
                void'(push_cyc_q.pop_front());
            end
            if (m_hold > 0) m_hold--;
            if (push_now && exp_q.size() == FIFO_DEPTH && !pop_now) m_ovf = 1'b1;
            else if (push_now) accept = 1'b1;
            if (pop_now) void'(exp_q.pop_front());
            if (accept) begin
                exp_q.push_back(ev);
                if (!ev[8]) m_hold = HOLD_CYCLES;
            end
            if (err_q.size() > 0 && err_q[0] == cyc) begin
                exp_err = 1'b1;
                void'(err_q.pop_front());
            end
        end
        if (live) begin
            chk("key_valid",  int'(key_valid),  int'(exp_q.size() > 0));
            chk("key_code",   int'(key_code),   (exp_q.size() > 0) ? int'(exp_q[0][7:0]) : 0);
            chk("key_break",  int'(key_break),  (exp_q.size() > 0) ? int'(exp_q[0][8]) : 0);
            chk("key_ext",    int'(key_ext),    (exp_q.size() > 0) ? int'(exp_q[0][9]) : 0);
            chk("fifo_count", int'(fifo_count), exp_q.size());
            chk("overflow",   int'(overflow),   int'(m_ovf));
            chk("hold_en",    int'(hold_en),    int'(m_hold > 0));
            chk("frame_err",  int'(frame_err),  int'(exp_err));
            if (key_valid && !kv_prev) valid_rise_cyc = cyc;
            if (hold_en && !he_prev)   hold_rise_cyc = cyc;
            if (!hold_en && he_prev)   hold_fall_cyc = cyc;
            if (frame_err) begin
                err_cnt++;
                err_last_cyc = cyc;
            end
            kv_prev = key_valid;
            he_prev = hold_en;
        end
        rst_prev   = rst;
        ready_prev = key_ready;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_tick();
        @(negedge clk);
        while (tb_div != CLK_DIV - 1) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    // mode 0: bits only, 1: full frame fed to the model, 2: partial frame that must time out
    task automatic send_bits(input logic [10:0] bits, input int n, input int mode,
                             input logic [7:0] b, input logic ok, output int last_edge);
        last_edge = 0;
        for (int i = 0; i < n; i++) begin
            wait_tick();
            ps2_data = bits[i];
            wait_tick();
            ps2_clk   = 1'b0;
            last_edge = cyc;
            if (mode == 1 && i == n - 1) model_frame(b, ok, last_edge);
            wait_tick();
            wait_tick();
            ps2_clk = 1'b1;
        end
        if (mode == 2) begin
            err_q.push_back(last_edge + CLK_DIV * (TIMEOUT_TICKS + 1));
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        wait_tick();
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic ok);
        return {1'b1, (~^b) ^ ~ok, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic ok, output int e);
        send_bits(make_frame(b, ok), 11, 1, b, ok, e);
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 key_ready = 1'b1;
        @(posedge clk);
        #1 key_ready = 1'b0;
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int e, e0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // 1: single make 5A, latency and hold window
        send_frame(8'h5A, 1'b1, e);
        chk("t1_valid_latency", valid_rise_cyc, e + 6);
        chk("t1_code", int'(key_code), 'h5A);
        chk("t1_count", int'(fifo_count), 1);
        chk("t1_hold_rise", hold_rise_cyc, e + 6);
        wait_until(e + 6 + HOLD_CYCLES + 2);
        chk("t1_hold_len", hold_fall_cyc - hold_rise_cyc, 60);
        pop_one();
        chk("t1_popped", int'(fifo_count), 0);

        // 2: extended break E0 F0 75
        send_frame(8'hE0, 1'b1, e);
        chk("t2_no_ev_e0", int'(fifo_count), 0);
        send_frame(8'hF0, 1'b1, e);
        chk("t2_no_ev_f0", int'(fifo_count), 0);
        send_frame(8'h75, 1'b1, e);
        chk("t2_count", int'(fifo_count), 1);
        chk("t2_code", int'(key_code), 'h75);
        chk("t2_ext", int'(key_ext), 1);
        chk("t2_brk", int'(key_break), 1);
        chk("t2_hold", int'(hold_en), 0);
        pop_one();

        // 3: bad parity, then a good frame
        e0 = err_cnt;
        send_frame(8'h29, 1'b0, e);
        chk("t3_err_pulses", err_cnt - e0, 1);
        chk("t3_err_cycle", err_last_cyc, e + 5);
        chk("t3_no_event", int'(fifo_count), 0);
        send_frame(8'h66, 1'b1, e);
        chk("t3_code", int'(key_code), 'h66);
        chk("t3_flags", int'({key_ext, key_break}), 0);
        pop_one();

        // 4: five bits then silence, then a full 72 frame
        e0 = err_cnt;
        send_bits(make_frame(8'h33, 1'b1), 5, 2, 8'h33, 1'b1, e);
        wait_until(e + 52 + 3);
        chk("t4_timeout_pulses", err_cnt - e0, 1);
        chk("t4_timeout_cycle", err_last_cyc, e + 52);
        send_frame(8'h72, 1'b1, e);
        chk("t4_code", int'(key_code), 'h72);
        chk("t4_count", int'(fifo_count), 1);
        pop_one();

        // 5: overflow with the consumer stalled
        for (int i = 1; i <= FIFO_DEPTH + 1; i++) send_frame(8'(i), 1'b1, e);
        chk("t5_overflow", int'(overflow), 1);
        chk("t5_count", int'(fifo_count), 8);
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            @(posedge clk);
            #1;
            chk("t5_pop_code", int'(key_code), i);
            key_ready = 1'b1;
            @(posedge clk);
            #1 key_ready = 1'b0;
        end
        chk("t5_drained", int'(key_valid), 0);

        // 6: reset in the middle of a frame
        send_bits(make_frame(8'h5A, 1'b1), 6, 0, 8'h5A, 1'b1, e);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_rst_outputs",
            int'({key_valid, key_code, key_ext, key_break, frame_err, overflow, hold_en}), 0);
        chk("t6_rst_count", int'(fifo_count), 0);
        rst = 1'b0;
        send_frame(8'h5A, 1'b1, e);
        chk("t6_code", int'(key_code), 'h5A);
        chk("t6_count", int'(fifo_count), 1);
        pop_one();

        repeat (10) @(posedge clk);
        finish_run();
    end

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        finish_run();
    end

endmodule
